// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encodings, default
// parameter values and the retire-destination rule.
package mc_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_ERR    = 3'd7
    } state_t;

    localparam int DEF_TIMEOUT = 255;
    localparam int DEF_CNT_W   = 32;

    // Where an instruction goes after its retire cycle.
    function automatic state_t retire_next(input logic sys, input logic run_en);
        if (sys) return S_HALT;
        return run_en ? S_FETCH : S_IDLE;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive unacknowledged memory-request cycles and flags the cycle
// in which the wait limit is reached; a limit of 0 never expires.
module mem_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    input  logic ack,
    output logic expired
);

    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [W-1:0] LAST = (TIMEOUT > 0) ? W'(TIMEOUT - 1) : '0;

    logic [W-1:0] cnt;
    logic [W-1:0] cur;

    // start marks the first cycle of a request, so a stale count is never seen.
    assign cur = start ? '0 : cnt;

    always_comb begin
        expired = (TIMEOUT != 0) && active && !ack && (cur == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (active && !ack) begin
            cnt <= cur + W'(1);
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle instruction sequencer: steps FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath strobes, counts retired instructions and owns HALT and ERR.
module mc_sequencer
    import mc_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_en,
    input  logic             resume,
    input  logic             reg_we,
    input  logic             mem_we,
    input  logic             mem_to_reg,
    input  logic             sys,
    input  logic             mem_ack,
    output logic             mem_req,
    output logic             mem_wr,
    output logic             addr_sel,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic             halted,
    output logic             err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_cnt
);

    state_t cur_state;
    logic   entry;
    logic   expired;
    logic   retire;

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .start   (entry),
        .active  (mem_req),
        .ack     (mem_ack),
        .expired (expired)
    );

    always_comb begin
        retire = 1'b0;
        case (cur_state)
            S_EXEC:  retire = !(mem_we || mem_to_reg) && !reg_we;
            S_MEM:   retire = mem_ack && !mem_to_reg;
            S_WB:    retire = 1'b1;
            default: retire = 1'b0;
        endcase
    end

    always_comb begin
        mem_req  = (cur_state == S_FETCH) || (cur_state == S_MEM);
        mem_wr   = (cur_state == S_MEM) && mem_we;
        addr_sel = (cur_state == S_MEM);
        ir_we    = (cur_state == S_FETCH) && mem_ack;
        pc_we    = retire;
        rf_we    = (cur_state == S_WB) && reg_we;
        halted   = (cur_state == S_HALT);
        err      = (cur_state == S_ERR);
    end

    assign state = cur_state;

    // entry is high during the first cycle of every FETCH/MEM visit.
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state <= S_IDLE;
            entry     <= 1'b0;
            instr_cnt <= '0;
        end else begin
            entry <= 1'b0;
            if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
            case (cur_state)
                S_IDLE: begin
                    if (run_en) begin
                        cur_state <= S_FETCH;
                        entry     <= 1'b1;
                    end
                end
                S_FETCH: begin
                    if (mem_ack)      cur_state <= S_DECODE;
                    else if (expired) cur_state <= S_ERR;
                end
                S_DECODE: cur_state <= S_EXEC;
                S_EXEC: begin
                    if (mem_we || mem_to_reg) begin
                        cur_state <= S_MEM;
                        entry     <= 1'b1;
                    end else if (reg_we) begin
                        cur_state <= S_WB;
                    end else begin
                        cur_state <= retire_next(sys, run_en);
                        entry     <= run_en && !sys;
                    end
                end
                S_MEM: begin
                    if (mem_ack) begin
                        if (mem_to_reg) begin
                            cur_state <= S_WB;
                        end else begin
                            cur_state <= retire_next(sys, run_en);
                            entry     <= run_en && !sys;
                        end
                    end else if (expired) begin
                        cur_state <= S_ERR;
                    end
                end
                S_WB: begin
                    cur_state <= retire_next(sys, run_en);
                    entry     <= run_en && !sys;
                end
                S_HALT: begin
                    if (resume) begin
                        cur_state <= run_en ? S_FETCH : S_IDLE;
                        entry     <= run_en;
                    end
                end
                default: cur_state <= S_ERR;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: builds per-cycle expectations from instruction
// phases (fetch, decode, execute, memory, write-back) and replays them.
module tb_mc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_en = 1'b0;
    logic        resume = 1'b0;
    logic        reg_we = 1'b0;
    logic        mem_we = 1'b0;
    logic        mem_to_reg = 1'b0;
    logic        sys = 1'b0;
    logic        mem_ack = 1'b0;
    logic        mem_req, mem_wr, addr_sel, ir_we, pc_we, rf_we, halted, err;
    logic [2:0]  state;
    logic [31:0] instr_cnt;

    int checks = 0;
    int failures = 0;
    logic [31:0] model_cnt = 0;

    mc_sequencer #(.TIMEOUT(4), .CNT_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .run_en     (run_en),
        .resume     (resume),
        .reg_we     (reg_we),
        .mem_we     (mem_we),
        .mem_to_reg (mem_to_reg),
        .sys        (sys),
        .mem_ack    (mem_ack),
        .mem_req    (mem_req),
        .mem_wr     (mem_wr),
        .addr_sel   (addr_sel),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .rf_we      (rf_we),
        .halted     (halted),
        .err        (err),
        .state      (state),
        .instr_cnt  (instr_cnt)
    );

    always #5 clk = ~clk;

    // One expected cycle: inputs to apply and outputs required.
    typedef struct packed {
        logic [2:0] st;
        logic req, wr, asel, ir, pc, rf, hlt, er;
        logic ack, run, res, rw, mw, m2r, sy;
    } cyc_t;

    cyc_t exp_q[$];

    function automatic cyc_t blank(input logic rw, mw, m2r, sy, run);
        cyc_t c;
        c = '0;
        c.rw = rw; c.mw = mw; c.m2r = m2r; c.sy = sy; c.run = run;
        return c;
    endfunction

    task automatic push_idle(input int n, input logic run, input logic res);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = blank(1'b0, 1'b0, 1'b0, 1'b0, run);
            c.res = res;
            exp_q.push_back(c);
        end
    endtask

    // An instruction as phases; run_late is run_en from EXEC through retire.
    task automatic push_instr(input logic rw, mw, m2r, sy, input int wf, wm, input logic run_late);
        cyc_t c;
        logic memop;
        memop = mw | m2r;
        for (int i = 0; i <= wf; i++) begin
            c = blank(rw, mw, m2r, sy, 1'b1);
            c.st = 3'd1; c.req = 1'b1; c.ack = (i == wf); c.ir = (i == wf);
            exp_q.push_back(c);
        end
        c = blank(rw, mw, m2r, sy, 1'b1);
        c.st = 3'd2;
        exp_q.push_back(c);
        c = blank(rw, mw, m2r, sy, run_late);
        c.st = 3'd3; c.pc = !memop && !rw;
        exp_q.push_back(c);
        if (memop) begin
            for (int i = 0; i <= wm; i++) begin
                c = blank(rw, mw, m2r, sy, run_late);
                c.st = 3'd4; c.req = 1'b1; c.wr = mw; c.asel = 1'b1;
                c.ack = (i == wm); c.pc = (i == wm) && !m2r;
                exp_q.push_back(c);
            end
        end
        if (m2r || (rw && !memop)) begin
            c = blank(rw, mw, m2r, sy, run_late);
            c.st = 3'd5; c.rf = rw; c.pc = 1'b1;
            exp_q.push_back(c);
        end
    endtask

    task automatic push_halt(input int n, input logic run);
        cyc_t c;
        for (int i = 0; i <= n; i++) begin
            c = blank(1'b0, 1'b0, 1'b0, 1'b0, run);
            c.st = 3'd6; c.hlt = 1'b1; c.res = (i == n);
            exp_q.push_back(c);
        end
    endtask

    // Called at posedge+1; leaves at posedge+1.
    task automatic run_q(input string tag, input int limit);
        cyc_t c;
        logic [10:0] got, want;
        int n;
        n = 0;
        while (exp_q.size() > 0 && (limit < 0 || n < limit)) begin
            c = exp_q.pop_front();
            mem_ack = c.ack; run_en = c.run; resume = c.res;
            reg_we = c.rw; mem_we = c.mw; mem_to_reg = c.m2r; sys = c.sy;
            @(negedge clk);
            got  = {state, mem_req, mem_wr, addr_sel, ir_we, pc_we, rf_we, halted, err};
            want = {c.st, c.req, c.wr, c.asel, c.ir, c.pc, c.rf, c.hlt, c.er};
            checks++;
            if (got !== want) begin
                failures++;
                $display("FAIL %s cycle %0d outputs {state,req,wr,asel,ir,pc,rf,halted,err}: got %b want %b",
                         tag, n, got, want);
            end
            checks++;
            if (instr_cnt !== model_cnt) begin
                failures++;
                $display("FAIL %s cycle %0d instr_cnt: got %0d want %0d", tag, n, instr_cnt, model_cnt);
            end
            if (c.pc) model_cnt++;
            @(posedge clk); #1;
            n++;
        end
        exp_q.delete();
        mem_ack = 1'b0; resume = 1'b0;
    endtask

    task automatic do_reset(input logic ack_during);
        rst = 1'b1; mem_ack = ack_during;
        @(posedge clk); #1;
        rst = 1'b0; mem_ack = 1'b0;
        model_cnt = 0;
    endtask

    task automatic test_reset();
        run_en = 1'b1;
        do_reset(1'b0);
        push_idle(1, 1'b0, 1'b0);
        run_q("reset", -1);
    endtask

    task automatic test_addu();
        push_idle(1, 1'b1, 1'b0);
        push_instr(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        push_idle(1, 1'b0, 1'b0);
        run_q("addu", -1);
    endtask

    task automatic test_lw_wait();
        push_idle(1, 1'b1, 1'b0);
        push_instr(1'b1, 1'b0, 1'b1, 1'b0, 0, 3, 1'b0);
        push_idle(1, 1'b0, 1'b0);
        run_q("lw_wait3", -1);
    endtask

    task automatic test_sw_beq();
        push_idle(1, 1'b1, 1'b0);
        push_instr(1'b0, 1'b1, 1'b0, 1'b0, 1, 0, 1'b1);
        push_instr(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        push_idle(1, 1'b0, 1'b0);
        run_q("sw_beq", -1);
    endtask

    task automatic test_syscall();
        push_idle(1, 1'b0, 1'b1);
        push_idle(1, 1'b1, 1'b0);
        push_instr(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
        push_halt(10, 1'b1);
        push_instr(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1);
        push_instr(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
        push_halt(2, 1'b0);
        push_idle(1, 1'b0, 1'b0);
        run_q("syscall", -1);
    endtask

    task automatic test_timeout();
        cyc_t c;
        push_idle(1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            c = blank(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            c.st = 3'd1; c.req = 1'b1;
            exp_q.push_back(c);
        end
        for (int i = 0; i < 6; i++) begin
            c = blank(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            c.st = 3'd7; c.er = 1'b1; c.ack = i[0]; c.res = 1'b1;
            exp_q.push_back(c);
        end
        run_q("timeout_err", -1);
        run_en = 1'b0;
        do_reset(1'b0);
        push_idle(1, 1'b1, 1'b0);
        push_instr(1'b0, 1'b1, 1'b0, 1'b0, 3, 3, 1'b0);
        push_idle(1, 1'b0, 1'b0);
        run_q("timeout_ack4", -1);
    endtask

    task automatic test_reset_mid_mem();
        push_idle(1, 1'b1, 1'b0);
        push_instr(1'b1, 1'b0, 1'b1, 1'b0, 0, 3, 1'b1);
        run_q("rst_mem_pre", 6);
        run_en = 1'b0;
        do_reset(1'b1);
        push_idle(2, 1'b0, 1'b0);
        run_q("rst_mem", -1);
    endtask

    task automatic test_run_drop();
        push_idle(1, 1'b1, 1'b0);
        push_instr(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        push_idle(2, 1'b0, 1'b0);
        push_idle(1, 1'b1, 1'b0);
        push_instr(1'b1, 1'b0, 1'b1, 1'b0, 2, 1, 1'b0);
        push_idle(2, 1'b0, 1'b0);
        run_q("run_drop", -1);
    endtask

    task automatic test_back_to_back();
        int kind;
        logic rw, mw, m2r;
        push_idle(1, 1'b1, 1'b0);
        for (int k = 0; k < 40; k++) begin
            kind = int'($urandom_range(0, 4));
            rw  = (kind == 0) || (kind == 1) || (kind == 4);
            mw  = (kind == 2);
            m2r = (kind == 1);
            push_instr(rw, mw, m2r, 1'b0, int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), k != 39);
        end
        push_idle(2, 1'b0, 1'b0);
        run_q("back_to_back", -1);
    endtask

    initial begin
        test_reset();
        test_addu();
        test_lw_wait();
        test_sw_beq();
        test_syscall();
        test_timeout();
        test_reset_mid_mem();
        test_run_drop();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
